trans_validator_p: RTL and testbench

Parametrised successor to the single-ledger transaction validator. It takes fixed-format transfer records from the ingest path, finds or allocates the sender and receiver accounts in an on-chip balance table, and checks funds and overflow. Accepted transfers are written back to the table. Unlike the previous generation, every record is echoed downstream with a status code, the input has ready/valid backpressure, the table has a full condition, and there is a synchronous reset.

---
 rtl/trans_validator_p.sv | 217 +++++++++++++++++++++
 tb/tb_trans_validator_p.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/trans_validator_p.sv
`default_nettype none
// ============================================================================
// Module      : trans_validator_p
// Description : Ledger transfer validator. Looks up (or allocates) the sender
//               and receiver in an on-chip balance table, checks funds, table
//               capacity and receiver overflow, writes accepted transfers back
//               and echoes every record downstream with a status code.
// Revision    : 1.0 - initial release
// ============================================================================
module trans_validator_p #(
    parameter int ID_W     = 48,
    parameter int BAL_W    = 24,
    parameter int DEPTH    = 16384,
    parameter int INIT_BAL = 100,
    localparam int TX_W    = 2*ID_W + 32,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [TX_W-1:0] data_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [TX_W-1:0] data_o,
    output logic            valid_o,
    output logic [1:0]      status_o,
    output logic [CW-1:0]   count_o
);

    localparam int AW    = CW - 1;
    localparam int E_W   = ID_W + BAL_W;
    localparam int AMT_W = 22;
    // Arithmetic width wide enough for both the amount and a balance plus carry
    localparam int EXT_W = ((BAL_W > AMT_W) ? BAL_W : AMT_W) + 1;

    localparam logic [EXT_W-1:0] OVF_LIM = EXT_W'(1) << BAL_W;
    localparam logic [BAL_W-1:0] INIT_B  = BAL_W'(INIT_BAL);
    localparam logic [CW:0]      DEPTH_X = (CW+1)'(DEPTH);

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_NOFUNDS = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;
    localparam logic [1:0] ST_OVF     = 2'd3;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SCAN   = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_WR_SND = 3'd3;
    localparam logic [2:0] S_WR_RCV = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [TX_W-1:0]  rec_q;
    logic [CW-1:0]    scan_idx_q;
    logic             rd_vld_q;
    logic             snd_found_q, rcv_found_q;
    logic [BAL_W-1:0] snd_bal_q, rcv_bal_q;
    logic [AW-1:0]    snd_addr_q, rcv_addr_q;
    logic [BAL_W-1:0] snd_new_q, rcv_new_q;
    logic [AW-1:0]    snd_wa_q, rcv_wa_q;
    logic [1:0]       needed_q;
    logic [CW-1:0]    count_q;
    logic             valid_q;
    logic [1:0]       status_q;
    logic [TX_W-1:0]  dout_q;

    logic [E_W-1:0]   mem [DEPTH];
    logic [E_W-1:0]   rdata_q;
    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    logic [E_W-1:0]   ram_wdata;
    logic [AW-1:0]    ram_raddr;

    logic [ID_W-1:0]  w_snd_id, w_rcv_id, w_rd_id;
    logic [AMT_W-1:0] w_amt;
    logic             w_self, w_hs;
    logic [BAL_W-1:0] w_rd_bal;
    logic             w_snd_hit, w_rcv_hit, w_both, w_scan_done;
    logic [AW-1:0]    w_prev_idx, w_cnt_a;
    logic [1:0]       w_needed;
    logic             w_full, w_nofunds, w_ovf;
    logic [BAL_W-1:0] w_s_bal, w_r_bal;
    logic [EXT_W-1:0] w_snd_sub, w_rcv_add;
    logic [1:0]       w_status;

    assign w_snd_id = rec_q[TX_W-1 -: ID_W];
    assign w_rcv_id = rec_q[31+ID_W -: ID_W];
    assign w_amt    = rec_q[31:10];
    assign w_self   = (w_snd_id == w_rcv_id);
    assign w_hs     = valid_i && ready_o;

    // Scan compare: rdata_q holds the entry addressed one cycle earlier
    assign w_rd_id     = rdata_q[E_W-1 -: ID_W];
    assign w_rd_bal    = rdata_q[BAL_W-1:0];
    assign w_prev_idx  = scan_idx_q[AW-1:0] - AW'(1);
    assign w_snd_hit   = rd_vld_q && !snd_found_q && (w_rd_id == w_snd_id);
    assign w_rcv_hit   = rd_vld_q && !rcv_found_q && (w_rd_id == w_rcv_id);
    assign w_both      = (snd_found_q || w_snd_hit) && (w_self || rcv_found_q || w_rcv_hit);
    assign w_scan_done = (rd_vld_q && w_both) || (scan_idx_q == count_q);

    // Rule evaluation in CHECK; unfound accounts open at INIT_BAL
    assign w_needed  = 2'(!snd_found_q) + 2'(!rcv_found_q && !w_self);
    assign w_full    = ({1'b0, count_q} + (CW+1)'(w_needed)) > DEPTH_X;
    assign w_s_bal   = snd_found_q ? snd_bal_q : INIT_B;
    assign w_r_bal   = rcv_found_q ? rcv_bal_q : INIT_B;
    assign w_snd_sub = EXT_W'(w_s_bal) - EXT_W'(w_amt);
    assign w_rcv_add = EXT_W'(w_r_bal) + EXT_W'(w_amt);
    assign w_nofunds = EXT_W'(w_s_bal) < EXT_W'(w_amt);
    assign w_ovf     = !w_self && (w_rcv_add >= OVF_LIM);
    assign w_status  = w_full ? ST_FULL : (w_nofunds ? ST_NOFUNDS : (w_ovf ? ST_OVF : ST_OK));
    assign w_cnt_a   = count_q[AW-1:0];

    assign data_o   = dout_q;
    assign valid_o  = valid_q;
    assign status_o = status_q;
    assign count_o  = count_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (w_hs) state_d = (data_i[9] || count_q == '0) ? S_CHECK : S_SCAN;
            S_SCAN:   if (w_scan_done) state_d = S_CHECK;
            S_CHECK:  state_d = (w_status == ST_OK) ? S_WR_SND : S_IDLE;
            S_WR_SND: state_d = w_self ? S_IDLE : S_WR_RCV;
            S_WR_RCV: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: handshake readiness and table port control
    always_comb begin
        ready_o   = (state_q == S_IDLE) && !rst;
        ram_we    = !rst && ((state_q == S_WR_SND) || (state_q == S_WR_RCV));
        ram_waddr = (state_q == S_WR_RCV) ? rcv_wa_q : snd_wa_q;
        ram_wdata = (state_q == S_WR_RCV) ? {w_rcv_id, rcv_new_q} : {w_snd_id, snd_new_q};
        ram_raddr = scan_idx_q[AW-1:0];
    end

    // Balance table: one write port, registered read, contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        rdata_q <= mem[ram_raddr];
    end

    // Datapath: record latch, scan tracking, check results and entry count
    always_ff @(posedge clk) begin
        if (rst) begin
            rec_q       <= '0;
            scan_idx_q  <= '0;
            rd_vld_q    <= 1'b0;
            snd_found_q <= 1'b0;
            rcv_found_q <= 1'b0;
            snd_bal_q   <= '0;
            rcv_bal_q   <= '0;
            snd_addr_q  <= '0;
            rcv_addr_q  <= '0;
            snd_new_q   <= '0;
            rcv_new_q   <= '0;
            snd_wa_q    <= '0;
            rcv_wa_q    <= '0;
            needed_q    <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            status_q    <= ST_OK;
            dout_q      <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_hs) begin
                        rec_q       <= data_i;
                        scan_idx_q  <= '0;
                        rd_vld_q    <= 1'b0;
                        snd_found_q <= 1'b0;
                        rcv_found_q <= 1'b0;
                        // A new block abandons all existing entries
                        if (data_i[9]) count_q <= '0;
                    end
                end
                S_SCAN: begin
                    scan_idx_q <= scan_idx_q + CW'(1);
                    rd_vld_q   <= (scan_idx_q < count_q);
                    if (w_snd_hit) begin
                        snd_found_q <= 1'b1;
                        snd_bal_q   <= w_rd_bal;
                        snd_addr_q  <= w_prev_idx;
                    end
                    if (w_rcv_hit) begin
                        rcv_found_q <= 1'b1;
                        rcv_bal_q   <= w_rd_bal;
                        rcv_addr_q  <= w_prev_idx;
                    end
                end
                S_CHECK: begin
                    valid_q   <= 1'b1;
                    status_q  <= w_status;
                    dout_q    <= rec_q;
                    needed_q  <= w_needed;
                    snd_new_q <= w_self ? w_s_bal : w_snd_sub[BAL_W-1:0];
                    rcv_new_q <= w_rcv_add[BAL_W-1:0];
                    snd_wa_q  <= snd_found_q ? snd_addr_q : w_cnt_a;
                    rcv_wa_q  <= rcv_found_q ? rcv_addr_q :
                                 (snd_found_q ? w_cnt_a : w_cnt_a + AW'(1));
                end
                S_WR_SND: count_q <= count_q + CW'(needed_q);
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trans_validator_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_trans_validator_p
// Description : Scoreboard bench for trans_validator_p (ID_W=8, BAL_W=8,
//               DEPTH=4, INIT_BAL=200). Stimulus pushes hand-computed results;
//               a monitor pops and compares on every valid_o pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trans_validator_p;

    localparam logic [1:0] OK = 2'd0, NOF = 2'd1, FULL = 2'd2, OVF = 2'd3;
    localparam logic [7:0] A = 8'h0A, B = 8'h0B, C = 8'h0C, D = 8'h0D, E = 8'h0E,
                           F = 8'h0F, G = 8'h1A, H = 8'h1B, I = 8'h1C, J = 8'h1D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [47:0] data_o;
    logic        valid_o;
    logic [1:0]  status_o;
    logic [2:0]  count_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [47:0] d;
        logic [1:0]  st;
        logic [2:0]  cnt;
        int          at;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    trans_validator_p #(.ID_W(8), .BAL_W(8), .DEPTH(4), .INIT_BAL(200)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_o(data_o), .valid_o(valid_o), .status_o(status_o), .count_o(count_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    function automatic logic [47:0] mk(input logic [7:0] s, input logic [7:0] r,
                                       input int amt, input bit bs, input logic [8:0] tag);
        logic [21:0] a;
        a = 22'(amt);
        return {s, r, a, bs, tag};
    endfunction

    // Issue one record; s = scan cycles, rl = expected ready-return latency (0: skip)
    task automatic send(input logic [47:0] rec, input logic [1:0] st, input logic [2:0] cnt,
                        input int s, input int rl, input bit hold, input bit expect_res);
        int g;
        exp_t x;
        data_i  = rec;
        valid_i = 1'b1;
        g = 0;
        while (!ready_o && g < 60) begin
            @(negedge clk);
            g++;
        end
        if (!ready_o) begin
            chk("handshake_timeout", {63'd0, ready_o}, 64'd1);
            valid_i = 1'b0;
            return;
        end
        if (expect_res) begin
            x.d = rec; x.st = st; x.cnt = cnt; x.at = cyc + 2 + s;
            sb.push_back(x);
        end
        @(negedge clk);
        if (!hold) valid_i = 1'b0;
        if (rl > 0) begin
            g = 1;
            while (!ready_o && g < 60) begin
                @(negedge clk);
                g++;
            end
            chk("ready_latency", 64'(g), 64'(rl));
        end
        if (!hold) @(negedge clk);
    endtask

    // Monitor: compare each result pulse against the oldest expectation
    initial begin
        forever begin
            @(negedge clk);
            if (valid_o) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got data %0h status %0d, want no result", data_o, status_o);
                end else begin
                    e = sb.pop_front();
                    chk("res_data", 64'(data_o), 64'(e.d));
                    chk("res_status", 64'(status_o), 64'(e.st));
                    chk("res_cycle", 64'(cyc), 64'(e.at));
                    @(negedge clk);
                    chk("count_after", 64'(count_o), 64'(e.cnt));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_status", 64'(status_o), 64'd0);
        chk("rst_data", 64'(data_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(ready_o), 64'd1);

        // New block: both allocated, A=170 B=230
        send(mk(A, B, 30, 1, 9'h001), OK, 3'd2, 0, 4, 0, 1);
        send(mk(B, A, 231, 0, 9'h0F2), NOF, 3'd2, 3, 5, 0, 1);   // B=230 short by one
        send(mk(B, A, 230, 0, 9'h133), OVF, 3'd2, 3, 5, 0, 1);   // funds ok, A 400
        send(mk(B, A, 85, 0, 9'h044), OK, 3'd2, 3, 7, 0, 1);     // A=255 exactly
        send(mk(B, A, 1, 0, 9'h155), OVF, 3'd2, 3, 5, 0, 1);     // 256 overflows
        send(mk(A, A, 50, 0, 9'h066), OK, 3'd2, 2, 5, 0, 1);     // self, early exit
        send(mk(C, D, 0, 0, 9'h177), OK, 3'd4, 3, 7, 0, 1);      // fills table
        send(mk(E, A, 10, 0, 9'h088), FULL, 3'd4, 5, 7, 0, 1);   // one new ID
        send(mk(D, C, 55, 0, 9'h199), OK, 3'd4, 5, 9, 0, 1);     // full but no alloc
        send(mk(C, E, 0, 0, 9'h0AA), FULL, 3'd4, 5, 7, 0, 1);   // amount 0 still FULL
        send(mk(F, A, 5, 1, 9'h1BB), OK, 3'd2, 0, 4, 0, 1);      // block clears table
        send(mk(A, F, 206, 0, 9'h0CC), NOF, 3'd2, 3, 5, 0, 1);   // new A=205
        send(mk(F, A, 50, 0, 9'h1DD), OK, 3'd2, 3, 7, 0, 1);
        send(mk(G, G, 50, 1, 9'h0EE), OK, 3'd1, 0, 3, 0, 1);     // self on empty table
        send(mk(G, H, 201, 0, 9'h1FF), NOF, 3'd1, 2, 4, 0, 1);   // G unchanged at 200
        send(mk(G, H, 55, 0, 9'h011), OK, 3'd2, 2, 6, 0, 1);     // G=145 H=255

        // Back-to-back with valid_i held, then reset during the 2nd scan
        send(mk(G, H, 1, 0, 9'h022), OVF, 3'd2, 3, 5, 1, 1);
        send(mk(H, G, 1, 0, 9'h033), OK, 3'd2, 3, 7, 1, 1);
        send(mk(G, H, 1, 0, 9'h044), OK, 3'd2, 3, 0, 1, 0);
        rst     = 1'b1;
        valid_i = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 64'(ready_o), 64'd0);
        chk("midrst_count", 64'(count_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_ready", 64'(ready_o), 64'd1);
        for (int k = 0; k < 8; k++) begin
            chk("postrst_no_valid", 64'(valid_o), 64'd0);
            @(negedge clk);
        end
        chk("postrst_count", 64'(count_o), 64'd0);
        send(mk(I, J, 7, 0, 9'h155), OK, 3'd2, 0, 4, 0, 1);

        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
